truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around the 4-input combinational function block (F = ~D | C | B).
- Drives A, B, C, D through all 16 combinations in binary order and samples F after a programmable settle time.
- Assembles the 16-bit truth table and compares it against an expected constant.
- Used as the on-board self-check harness for the combinational lab circuits; one START gives one sweep.

Parameters:
- SETTLE_CYCLES, 1, clock cycles each input vector is held before F is sampled; legal range 1..15.
- EXPECTED, 16'hFDFD, golden truth table; bit i = F for index i = {A,B,C,D} with A as the MSB.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- START  in  1  level; a sweep is requested when START=1 is sampled in IDLE or DONE.
- A  out  1  stimulus bit 3 of the index (MSB).
- B  out  1  stimulus bit 2.
- C  out  1  stimulus bit 1.
- D  out  1  stimulus bit 0 (LSB).
- F  in  1  function output returned from the downstream block.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  high from sweep completion until the next START or reset.
- TABLE  out  16  captured truth table; bit i = sampled F for index i.
- MISMATCH  out  1  DONE && (TABLE != EXPECTED).
- ERR_COUNT  out  5  number of rows differing from EXPECTED (0..16).
- FIRST_ERR_IDX  out  4  lowest failing index; 0 when ERR_COUNT = 0.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - State goes to IDLE.
  - A=B=C=D=0, BUSY=0, DONE=0, TABLE=0, ERR_COUNT=0, FIRST_ERR_IDX=0, MISMATCH=0.
  - Settle counter and index are cleared.
- Reset mid-sweep aborts the sweep immediately, with no partial DONE.
- States: IDLE, DRIVE, DONE.
- IDLE -> DRIVE when START=1 at an edge:
  - index=0, settle counter=0.
  - TABLE, ERR_COUNT and FIRST_ERR_IDX are cleared.
  - BUSY=1 on the following cycle.
- DRIVE:
  - {A,B,C,D} = index, driven from registers (glitch-free).
  - The settle counter increments every cycle.
  - At the edge where the counter = SETTLE_CYCLES-1:
    - TABLE[index] <= F.
    - If F != EXPECTED[index]: ERR_COUNT += 1, and FIRST_ERR_IDX <= index if this is the first error of the sweep.
    - The counter resets to 0.
    - If index = 15, go to DONE; otherwise index += 1.
- DONE:
  - BUSY=0, DONE=1; A..D hold 4'hF.
  - MISMATCH is valid and TABLE is stable.
  - START=1 behaves as from IDLE (restart).
- Latency: with START sampled at edge k, samples occur at edges k+n*SETTLE_CYCLES for n=1..16. DONE=1 after edge k+16*SETTLE_CYCLES.
- START while BUSY=1 is ignored; the sweep is not restarted.
- START held high continuously gives back-to-back sweeps, each separated by exactly one DONE cycle.
- ERR_COUNT saturates naturally at 16 (5 bits, no wrap).
- Index wrap: the 15 -> 0 transition never occurs inside a sweep.
- Simultaneous RST_N=0 and START=1: reset wins.

Decomposition:
- Shared package holds:
  - The state enum {IDLE, DRIVE, DONE}.
  - IDX_W=4, N_ROWS=16.
  - The default EXPECTED constant 16'hFDFD.
  - A SETTLE_W derived width.
- One sub-module is natural: sweep_index_counter.
  - 4-bit index plus settle-cycle prescaler.
  - Outputs: sample strobe and last-row flag.
  - The top-level FSM and compare logic instantiate it.

Test Plan:
- Reset then idle, F tied to the real function block, START pulse, SETTLE_CYCLES=1:
  - BUSY for 16 cycles.
  - DONE one cycle after the last sample.
  - TABLE=16'hFDFD, MISMATCH=0, ERR_COUNT=0, FIRST_ERR_IDX=0.
- F tied to 1 with EXPECTED=16'hFDFD -> TABLE=16'hFFFF, MISMATCH=1, ERR_COUNT=2, FIRST_ERR_IDX=1.
- SETTLE_CYCLES=3, real function block:
  - Each ABCD vector held for exactly 3 cycles, observed as 0,0,0,1,1,1,...
  - DONE at edge k+48; TABLE=16'hFDFD.
- START pulsed at sweep row 5 -> ignored; the sweep completes normally at the original latency.
- RST_N=0 for one cycle at row 8:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A subsequent START gives a full, correct sweep.
- START held high through two sweeps:
  - DONE high for exactly 1 cycle between them.
  - TABLE cleared at the restart and equal to 16'hFDFD again at the second DONE.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg
// Shared constants and state encoding for the truth-table sweeper.
//   IDX_W            width of the row index ({A,B,C,D})
//   N_ROWS           number of truth-table rows swept
//   MAX_SETTLE       largest usable settle time in cycles
//   SETTLE_W         width of the settle-cycle prescaler
//   EXPECTED_DEFAULT golden table for F = ~D | C | B
//   ST_*             FSM state encodings
package truth_table_sweeper_pkg;

    localparam int IDX_W      = 4;
    localparam int N_ROWS     = 16;
    localparam int MAX_SETTLE = 15;
    localparam int SETTLE_W   = $clog2(MAX_SETTLE + 1);

    // F is low only for rows 1 (0001) and 9 (1001): B=0, C=0, D=1.
    localparam logic [N_ROWS-1:0] EXPECTED_DEFAULT = 16'hFDFD;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if
// Groups the sweeper's control, stimulus and result signals.
//   START          sweep request (level)
//   A, B, C, D     stimulus to the function block, A is the MSB
//   F              function block output returned to the sweeper
//   BUSY, DONE     sweep status
//   TABLE          captured truth table, bit i = F for row i
//   MISMATCH       DONE and TABLE differs from the golden table
//   ERR_COUNT      number of differing rows (0..16)
//   FIRST_ERR_IDX  lowest differing row, 0 when none
// master: the sweeper itself; slave: the surrounding board/bench.
interface truth_table_sweeper_if;

    import truth_table_sweeper_pkg::*;

    logic                START;
    logic                A;
    logic                B;
    logic                C;
    logic                D;
    logic                F;
    logic                BUSY;
    logic                DONE;
    logic [N_ROWS-1:0]   TABLE;
    logic                MISMATCH;
    logic [IDX_W:0]      ERR_COUNT;
    logic [IDX_W-1:0]    FIRST_ERR_IDX;

    modport master (
        input  START, F,
        output A, B, C, D, BUSY, DONE, TABLE, MISMATCH, ERR_COUNT, FIRST_ERR_IDX
    );

    modport slave (
        output START, F,
        input  A, B, C, D, BUSY, DONE, TABLE, MISMATCH, ERR_COUNT, FIRST_ERR_IDX
    );

endinterface

// File: rtl/truth_table_sweeper_index_counter.sv
// sweep_index_counter
// Row index plus settle-cycle prescaler for the truth-table sweep.
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   clear          restart at row 0 with an empty prescaler
//   enable         count while a sweep is driving
//   idx            current row index; doubles as the {A,B,C,D} register
//   sample_strobe  high on the last settle cycle of the current row
//   last_row       current row is the final one
module sweep_index_counter
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] idx,
    output logic             sample_strobe,
    output logic             last_row
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]    ROW_LAST    = IDX_W'(N_ROWS - 1);

    logic [SETTLE_W-1:0] settle_cnt;

    assign sample_strobe = enable && (settle_cnt == SETTLE_LAST);
    assign last_row      = (idx == ROW_LAST);

    // The index stops at the last row instead of wrapping, so after a sweep
    // the stimulus outputs rest at 4'hF without any extra muxing.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            settle_cnt <= '0;
            idx        <= '0;
        end else if (enable) begin
            if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                if (!last_row) begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Steps {A,B,C,D} through all 16 rows, samples F after SETTLE_CYCLES
// cycles per row, builds the truth table and compares it with EXPECTED.
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   bus            truth_table_sweeper_if master modport (START, F in;
//                  A..D, BUSY, DONE, TABLE, MISMATCH, ERR_COUNT,
//                  FIRST_ERR_IDX out)
// SETTLE_CYCLES must lie in 1..15.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                SETTLE_CYCLES = 1,
    parameter logic [N_ROWS-1:0] EXPECTED      = EXPECTED_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    truth_table_sweeper_if.master bus
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              sample_strobe;
    logic              last_row;
    logic              in_drive;
    logic              start_sweep;
    logic [N_ROWS-1:0] table_q;
    logic [IDX_W:0]    err_count;
    logic [IDX_W-1:0]  first_err_idx;

    assign in_drive    = (state == ST_DRIVE);
    assign start_sweep = bus.START && ((state == ST_IDLE) || (state == ST_DONE));

    sweep_index_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_index_counter (
        .clk           (CLK),
        .rst_n         (RST_N),
        .clear         (start_sweep),
        .enable        (in_drive),
        .idx           (idx),
        .sample_strobe (sample_strobe),
        .last_row      (last_row)
    );

    // Sweep FSM and capture. A non-zero error count already marks that the
    // first error has been seen, so no separate flag is kept.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= ST_IDLE;
            table_q       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        state         <= ST_DRIVE;
                        table_q       <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (sample_strobe) begin
                        table_q[idx] <= bus.F;
                        if (bus.F != EXPECTED[idx]) begin
                            err_count <= err_count + (IDX_W + 1)'(1);
                            if (err_count == '0) begin
                                first_err_idx <= idx;
                            end
                        end
                        if (last_row) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {bus.A, bus.B, bus.C, bus.D} = idx;
    assign bus.BUSY          = in_drive;
    assign bus.DONE          = (state == ST_DONE);
    assign bus.TABLE         = table_q;
    assign bus.MISMATCH      = (state == ST_DONE) && (table_q != EXPECTED);
    assign bus.ERR_COUNT     = err_count;
    assign bus.FIRST_ERR_IDX = first_err_idx;

endmodule
